// File: rtl/mem_pkg.sv
// Shared definitions for the matrix-engine RAM sequencer: FSM states, bus
// direction encodings and default RAM geometry.
package mem_pkg;

    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DATA_W = 256;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_TURN    = 3'd5
    } state_e;

endpackage

// File: rtl/mem_bus_drv.sv
// Tri-state driver for the shared RAM data bus; keeps inout handling out of
// the sequencer FSM.
module mem_bus_drv
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              oe_i,
    input  logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] in_o,
    inout  wire  [DATA_W-1:0] bus_io
);

    assign bus_io = oe_i ? out_i : {DATA_W{1'bz}};
    assign in_o   = bus_io;

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-master sequencer for the shared-bus RAM: one request at a time through
// SETUP/ACCESS/(CAPTURE)/TURN. Define MEM_ACCESS_CTRL_INIT_EN to zero the RAM after reset.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address_select,
    output logic              nEnable,
    output logic              ReadWrite,
    inout  wire  [DATA_W-1:0] dataBus,
    output state_e            dbg_state
);

`ifdef MEM_ACCESS_CTRL_INIT_EN
    localparam logic   INIT_EN     = 1'b1;
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam logic   INIT_EN     = 1'b0;
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              init_q, init_d;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            wr_q    <= INIT_EN;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            init_q  <= INIT_EN;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            init_q  <= init_d;
        end
    end

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // req_ready depends only on state, and an unaccepted request must be held.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        init_d  = init_q;
        unique case (state_q)
            // INIT is the setup cycle of an init write; the bus stays released
            // here so the reset-time bus/direction values hold while in reset.
            ST_INIT:    state_d = ST_ACCESS;
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:   state_d = ST_ACCESS;
            ST_ACCESS:  state_d = wr_q ? ST_TURN : ST_CAPTURE;
            ST_CAPTURE: begin
                rdata_d = bus_in;
                state_d = ST_TURN;
            end
            ST_TURN: begin
                if (init_q && (addr_q != {ADDR_W{1'b1}})) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_INIT;
                end else begin
                    init_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        nEnable        = !((state_q == ST_ACCESS) || (state_q == ST_CAPTURE));
        ReadWrite      = RW_READ;
        if ((state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_CAPTURE)) begin
            ReadWrite  = wr_q ? RW_WRITE : RW_READ;
        end
        bus_oe         = wr_q && ((state_q == ST_SETUP) || (state_q == ST_ACCESS));
        rsp_valid      = (state_q == ST_TURN) && !init_q;
        rsp_write      = rsp_valid && wr_q;
        rsp_rdata      = rdata_q;
        address_select = addr_q;
        dbg_state      = state_q;
    end

    mem_bus_drv #(
        .DATA_W (DATA_W)
    ) u_bus_drv (
        .oe_i   (bus_oe),
        .out_i  (wdata_q),
        .in_o   (bus_in),
        .bus_io (dataBus)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural shared-bus RAM; also covers
// the MEM_ACCESS_CTRL_INIT_EN build when that macro is defined.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int AW    = MEM_ADDR_W;
  localparam int DW    = MEM_DATA_W;
  localparam int DEPTH = 2 ** AW;
  localparam int EXP_W = DW + 33;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_rd;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_write, busy, nEnable, ReadWrite;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address_select;
  wire  [DW-1:0] dataBus;
  state_e        dbg_state;

  logic [DW-1:0] ram [DEPTH];
  logic          fill_en = 1'b1;
  logic [DW-1:0] fill_val = '0;

  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rd = '0;
  vec_t          tbl [19];

  mem_access_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata),
    .busy           (busy),
    .address_select (address_select),
    .nEnable        (nEnable),
    .ReadWrite      (ReadWrite),
    .dataBus        (dataBus),
    .dbg_state      (dbg_state)
  );

  // clock / reset-independent bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM: drives the bus while enabled for read, commits writes on posedge
  assign dataBus = (!nEnable && (ReadWrite == RW_READ)) ? ram[address_select] : {DW{1'bz}};
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= fill_val;
    end else if (!nEnable && (ReadWrite == RW_WRITE)) begin
      ram[address_select] <= dataBus;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic released();
    return (dataBus === {DW{1'bz}}) || (dataBus === {DW{1'b0}});
  endfunction

  // scoreboard: every response pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_write", rsp_write, mon_e[DW+32]);
        chk("rsp_rdata", rsp_rdata, mon_e[DW-1:0]);
        chk("rsp_cycle", cyc + 1, mon_e[DW+31:DW] + (mon_e[DW+32] ? 32'd3 : 32'd4));
      end
    end
  end

  // driver: call at a negedge; returns at the negedge inside SETUP
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] e);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles expected acceptance", n);
      req_valid = 1'b0;
    end else begin
      @(negedge clk);
      req_valid = 1'b0;
      exp_q.push_back({wr, cyc, e});
    end
  endtask

  task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] rd_exp);
    logic [DW-1:0] e;
    if (wr) begin
      ref_mem[a] = d;
      e = last_rd;
    end else begin
      e = rd_exp;
      last_rd = rd_exp;
    end
    issue(wr, a, d, e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int n;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, AW'(i), DW'(i), '0};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{1'b0, AW'(i), '0, DW'(i)};
    tbl[16] = '{1'b1, 3'd1, 256'hFFFF, '0};
    tbl[17] = '{1'b0, 3'd1, '0, 256'hFFFF};
    tbl[18] = '{1'b0, 3'd2, '0, 256'h2};

`ifdef MEM_ACCESS_CTRL_INIT_EN
    fill_val = {DW{1'b1}};
`endif
    repeat (3) @(negedge clk);
    fill_en = 1'b0;

    // reset values
    chk("rst_nEnable", nEnable, 1'b1);
    chk("rst_ReadWrite", ReadWrite, 1'b1);
    chk("rst_addr", address_select, '0);
    chk("rst_bus_released", released(), 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
`ifdef MEM_ACCESS_CTRL_INIT_EN
    chk("rst_busy", busy, 1'b1);
    chk("rst_req_ready", req_ready, 1'b0);
    reset = 1'b1;
    n = 1;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("init_cycles", n, 24);
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, AW'(i), '0, '0);
`else
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    reset = 1'b1;
`endif

    // single write: strobe sequence
    do_op(1'b1, 3'd3, 256'hA5, '0);
    chk("wr_setup_nEnable", nEnable, 1'b1);
    chk("wr_setup_rw", ReadWrite, RW_WRITE);
    chk("wr_setup_addr", address_select, 3'd3);
    @(negedge clk);
    chk("wr_access_nEnable", nEnable, 1'b0);
    chk("wr_access_rw", ReadWrite, RW_WRITE);
    chk("wr_access_bus", dataBus, 256'hA5);
    @(negedge clk);
    chk("wr_turn_nEnable", nEnable, 1'b1);
    chk("wr_turn_bus_released", released(), 1'b1);
    chk("wr_turn_req_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("wr_idle_req_ready", req_ready, 1'b1);

    // vector table: fill, read back, overwrite
    for (int i = 0; i < 19; i++) do_op(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd);

    // back-to-back write then read of the same address, request held
    wait_ready();
    d = 256'hC0FFEE_0000_1234_5678;
    do_op(1'b1, 3'd5, d, '0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd5;
    @(negedge clk);
    chk("b2b_access_bus", dataBus, d);
    @(negedge clk);
    chk("b2b_turn_bus_released", released(), 1'b1);
    chk("b2b_turn_req_ready", req_ready, 1'b0);
    do_op(1'b0, 3'd5, '0, d);
    chk("rd_setup_nEnable", nEnable, 1'b1);
    chk("rd_setup_rw", ReadWrite, RW_READ);
    @(negedge clk);
    chk("rd_access_nEnable", nEnable, 1'b0);
    @(negedge clk);
    chk("rd_capture_nEnable", nEnable, 1'b0);
    chk("rd_capture_rw", ReadWrite, RW_READ);
    @(negedge clk);
    chk("rd_turn_nEnable", nEnable, 1'b1);
    chk("rd_turn_bus_released", released(), 1'b1);

    // reset during ACCESS of a read
    wait_ready();
    do_op(1'b0, 3'd6, '0, 256'h6);
    @(negedge clk);
    chk("mid_pre_nEnable", nEnable, 1'b0);
    #2;
    reset = 1'b0;
    exp_q.delete();
    last_rd = '0;
    #1;
    chk("mid_rst_nEnable", nEnable, 1'b1);
    chk("mid_rst_bus_released", released(), 1'b1);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_rdata", rsp_rdata, '0);
`ifdef MEM_ACCESS_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    wait_ready();
`else
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
`endif

    // randomized traffic against the reference memory
    for (int k = 0; k < 40; k++) begin
      logic          wr;
      logic [AW-1:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, DEPTH - 1));
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
      do_op(wr, a, d, ref_mem[a]);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus-master sequencer that drives the 8-entry × 256-bit shared-bus RAM (`memory`) on behalf of the matrix-engine datapath. It accepts single read/write requests on a valid/ready port and generates the RAM strobes (`address_select`, `nEnable`, `ReadWrite`). It drives or releases the bidirectional `dataBus` with a guaranteed turnaround cycle, and returns read data as a one-cycle response pulse. It sits between the engine's load/store unit and the RAM.

## Interface
- `ADDR_W`, 3: RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 256: RAM word width.

- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_write`  out  1  type of the completed access.
- `rsp_rdata`  out  DATA_W  read data, valid with `rsp_valid` && !`rsp_write`.
- `busy`  out  1  high in any state other than IDLE.
- `address_select`  out  ADDR_W  RAM address.
- `nEnable`  out  1  RAM enable, active-low.
- `ReadWrite`  out  1  RAM direction: 1 = read, 0 = write.
- `dataBus`  inout  DATA_W  shared RAM data bus.

## Operation
- FSM states: INIT (config only), IDLE, SETUP, ACCESS, CAPTURE, TURN.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `req_write`/`req_addr`/`req_wdata` and go to SETUP.
- **SETUP** (1 cycle)
  - `address_select`=latched address.
  - `ReadWrite`=!write.
  - `nEnable`=1.
  - On a write, `dataBus` is driven with the latched data.
- **ACCESS** (1 cycle)
  - `nEnable`=0; address, direction and write data are held.
  - Write: the RAM commits at the posedge ending ACCESS; next state TURN.
  - Read: next state CAPTURE.
- **CAPTURE** (reads only, 1 cycle)
  - `nEnable`=0 and the controller does not drive the bus.
  - `rsp_rdata` is registered from `dataBus` at the posedge ending CAPTURE; next state TURN.
- **TURN** (1 cycle)
  - `nEnable`=1 and `dataBus` is released.
  - `rsp_valid`=1 and `rsp_write`=latched type.
  - Next state IDLE.
- **Bus drive rule:** the controller drives `dataBus` only in SETUP and ACCESS of a write; it is Z in every other state. TURN guarantees at least one undriven cycle between any write drive and any RAM read drive.
- Requests are not queued; `req_valid` while `req_ready`=0 is ignored and must be held by the requester.
- `rsp_rdata` holds its last captured value until the next read capture. A write never changes it.
- Out-of-range addresses are impossible by width; all 2^ADDR_W addresses are legal.

## Timing
- **Reset values:**
  - `nEnable`=1, `ReadWrite`=1, `address_select`=0.
  - `dataBus`=Z.
  - `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0.
  - `busy`=0 and `req_ready`=1 (no init), or `busy`=1 and `req_ready`=0 (init).
- Write: accept at edge N; SETUP N+1, ACCESS N+2, TURN N+3 (`rsp_valid`); `req_ready` returns in cycle N+4. Throughput is 1 write per 4 cycles.
- Read: accept at edge N; SETUP, ACCESS, CAPTURE, then TURN at N+4 with `rsp_valid` and data. Throughput is 1 read per 5 cycles.
- `rsp_valid` lasts exactly one cycle per request.
- Reset asserted mid-access:
  - immediately `nEnable`=1 and `dataBus`=Z;
  - the latched request is discarded and no `rsp_valid` is produced;
  - a write interrupted before the end of ACCESS is not guaranteed to be committed.
- Reset deassertion is sampled at posedge; the first acceptance is possible at the first posedge after release (no init).

## Configuration
- `MEM_ACCESS_CTRL_INIT_EN` defined:
  - after reset the FSM enters INIT and writes 0 to addresses 0..2^ADDR_W-1 in ascending order;
  - each address uses the SETUP/ACCESS/TURN write sequence (3 cycles), for 24 cycles at default parameters;
  - during INIT, `busy`=1, `req_ready`=0 and `rsp_valid` stays 0; IDLE follows the last TURN.
- Undefined: no INIT state; reset goes directly to IDLE, and RAM contents after reset are whatever the RAM holds.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum;
  - `RW_READ`=1 / `RW_WRITE`=0 encodings;
  - default `ADDR_W`/`DATA_W` constants, shared with `memory` and the testbench.
- Sub-module `mem_bus_drv`: tri-state driver, with output-enable, out-data and in-data ports, isolating the `inout` handling from the FSM.
- The top level holds the FSM, request latch, init counter and response registers.

## Test plan
- Reset, then write addr 3 = 256'hA5 -> `nEnable` is low for exactly one cycle at N+2 with `ReadWrite`=0 and the bus equal to A5; `rsp_valid` with `rsp_write`=1 at N+3.
- Write addresses 0..7 with value=address, then read 0..7 -> each `rsp_rdata` equals its address; `rsp_valid` arrives 4 cycles after each read accept.
- Overwrite addr 1 with 256'hFFFF, then read addr 1 -> FFFF; read addr 2 still returns 2.
- Bus contention check: back-to-back write addr 5 then read addr 5 with `req_valid` held -> `dataBus` is Z in TURN, no X on the bus, read returns the written value.
- Assert reset during ACCESS of a read -> `nEnable`=1 and `dataBus`=Z within the same cycle; no `rsp_valid`; `req_ready`=1 after release (no init).
- With `MEM_ACCESS_CTRL_INIT_EN`: preload RAM with nonzero data, reset -> `req_ready`=0 for 24 cycles; subsequent reads of 0..7 return 0.
